// File: rtl/bcd_updown_counter_n_if.sv
// Control and status bundle for bcd_updown_counter_n.
// The master side drives the step controls; the slave side is the counter itself.
interface bcd_updown_counter_n_if #(
    parameter int DIGITS = 2
);
    logic                  enable;
    logic                  clear;
    logic                  dir_in;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   q;
    logic                  dir_out;
    logic                  tc;

    modport master (
        output enable, clear, dir_in, load, load_val,
        input  q, dir_out, tc
    );

    modport slave (
        input  enable, clear, dir_in, load, load_val,
        output q, dir_out, tc
    );
endinterface

// File: rtl/bcd_updown_counter_n.sv
// Parametrised multi-digit BCD up/down counter with wrap (MODE 0) or bounce (MODE 1) behaviour.
// Define BCD_CNT_LOAD_EN to enable the range-checked parallel load; otherwise load/load_val are ignored.
module bcd_updown_counter_n #(
    parameter int DIGITS  = 2,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 31,
    parameter int MODE    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bcd_updown_counter_n_if.slave   cnt_if
);
    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] r;
        int           v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= 10**DIGITS - 1)) begin : g_bad_bounds
        $error("bcd_updown_counter_n: need 0 <= MIN_VAL < MAX_VAL <= 10**DIGITS-1");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("bcd_updown_counter_n: MODE must be 0 (wrap) or 1 (bounce)");
    end

    localparam logic [W-1:0] MIN_BCD    = to_bcd(MIN_VAL);
    localparam logic [W-1:0] MAX_BCD    = to_bcd(MAX_VAL);
    localparam logic [W-1:0] MIN_P1_BCD = to_bcd(MIN_VAL + 1);
    localparam logic [W-1:0] MAX_M1_BCD = to_bcd(MAX_VAL - 1);

    logic [W-1:0]      q_q, q_d;
    logic              dir_q, dir_d;
    logic              dir_eff;
    logic              at_max, at_min;
    logic              load_ok;
    logic [W-1:0]      step_val;
    logic [DIGITS-1:0] is_nine, is_zero, ripple;

    assign dir_eff = (MODE == 0) ? cnt_if.dir_in : dir_q;
    assign at_max  = (q_q == MAX_BCD);
    assign at_min  = (q_q == MIN_BCD);

    // A digit moves only when every lower digit is at its rollover value (9 up, 0 down).
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [3:0] d;
        assign d           = q_q[4*gi +: 4];
        assign is_nine[gi] = (d == 4'd9);
        assign is_zero[gi] = (d == 4'd0);
        if (gi == 0) begin : g_lsd
            assign ripple[gi] = 1'b1;
        end else begin : g_upper
            assign ripple[gi] = dir_eff ? (&is_nine[gi-1:0]) : (&is_zero[gi-1:0]);
        end
        assign step_val[4*gi +: 4] = !ripple[gi] ? d :
                                     dir_eff     ? (is_nine[gi] ? 4'd0 : d + 4'd1) :
                                                   (is_zero[gi] ? 4'd9 : d - 4'd1);
    end

`ifdef BCD_CNT_LOAD_EN
    logic [DIGITS-1:0] digit_ok;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_load_digit
        assign digit_ok[gi] = (cnt_if.load_val[4*gi +: 4] <= 4'd9);
    end
    // With every digit valid, BCD ordering equals plain unsigned ordering of the vector.
    assign load_ok = cnt_if.load && (&digit_ok)
                     && (cnt_if.load_val >= MIN_BCD) && (cnt_if.load_val <= MAX_BCD);
`else
    logic unused_load;
    assign unused_load = cnt_if.load;
    assign load_ok     = 1'b0;
`endif

    always_comb begin
        q_d   = q_q;
        dir_d = dir_q;
        if (cnt_if.clear) begin
            q_d   = MIN_BCD;
            dir_d = 1'b1;
        end else if (load_ok) begin
            q_d = cnt_if.load_val;
        end else if (cnt_if.enable) begin
            if (dir_eff && at_max) begin
                if (MODE == 0) begin
                    q_d = MIN_BCD;
                end else begin
                    q_d   = MAX_M1_BCD;
                    dir_d = 1'b0;
                end
            end else if (!dir_eff && at_min) begin
                if (MODE == 0) begin
                    q_d = MAX_BCD;
                end else begin
                    q_d   = MIN_P1_BCD;
                    dir_d = 1'b1;
                end
            end else begin
                q_d = step_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= MIN_BCD;
            dir_q <= 1'b1;
        end else begin
            q_q   <= q_d;
            dir_q <= dir_d;
        end
    end

    assign cnt_if.q       = q_q;
    assign cnt_if.dir_out = dir_eff;
    assign cnt_if.tc      = cnt_if.enable && (dir_eff ? at_max : at_min);

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: directed scenarios with literal expectations plus randomized
// traffic, all compared every negedge against an integer-valued model of the counting rules.
module tb_bcd_updown_counter_n;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

`ifdef BCD_CNT_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    bcd_updown_counter_n_if #(.DIGITS(2)) b_if ();
    bcd_updown_counter_n_if #(.DIGITS(2)) w_if ();
    bcd_updown_counter_n_if #(.DIGITS(3)) t_if ();

    bcd_updown_counter_n #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(31), .MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .cnt_if(b_if));
    bcd_updown_counter_n #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(31), .MODE(0)) u_w (
        .clk(clk), .rst_n(rst_n), .cnt_if(w_if));
    bcd_updown_counter_n #(.DIGITS(3), .MIN_VAL(0), .MAX_VAL(999), .MODE(0)) u_t (
        .clk(clk), .rst_n(rst_n), .cnt_if(t_if));

    function automatic logic [11:0] to_bcd(input int value);
        logic [11:0] r;
        int          v;
        r = '0;
        v = value;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    // Counting rules on a plain integer value.
    function automatic void model_next(input int digits, input int mn, input int mx, input int mode,
                                       input bit en, input bit clr, input bit ld, input bit di,
                                       input logic [11:0] lv, input int v, input bit d,
                                       output int nv, output bit nd);
        bit dn;
        bit ok;
        int lvv;
        dn  = (mode == 0) ? di : d;
        nv  = v;
        nd  = d;
        ok  = 1'b1;
        lvv = 0;
        for (int i = digits - 1; i >= 0; i--) begin
            if (lv[4*i +: 4] > 4'd9) ok = 1'b0;
            lvv = lvv * 10 + int'(lv[4*i +: 4]);
        end
        ok = ok && ld && (lvv >= mn) && (lvv <= mx) && LOAD_EN;
        if (clr) begin
            nv = mn;
            nd = 1'b1;
        end else if (ok) begin
            nv = lvv;
        end else if (en) begin
            if (dn) begin
                if (v == mx) begin
                    if (mode == 0) nv = mn;
                    else begin nv = mx - 1; nd = 1'b0; end
                end else nv = v + 1;
            end else begin
                if (v == mn) begin
                    if (mode == 0) nv = mx;
                    else begin nv = mn + 1; nd = 1'b1; end
                end else nv = v - 1;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string nm, input int mn, input int mx, input int mode,
                             input logic [11:0] q, input logic dout, input logic tc,
                             input bit en, input bit di, input int v, input bit d);
        bit exp_dir;
        bit exp_tc;
        exp_dir = (mode == 0) ? di : d;
        exp_tc  = en && ((exp_dir && v == mx) || (!exp_dir && v == mn));
        chk({nm, "_q"},   32'(q),    32'(to_bcd(v)));
        chk({nm, "_dir"}, 32'(dout), 32'(exp_dir));
        chk({nm, "_tc"},  32'(tc),   32'(exp_tc));
    endtask

    int mv [3];
    bit md [3];

    always @(posedge clk or negedge rst_n) begin : model_proc
        int nv;
        bit nd;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mv[i] <= 0;
                md[i] <= 1'b1;
            end
        end else begin
            model_next(2, 0, 31, 1, b_if.enable, b_if.clear, b_if.load, b_if.dir_in,
                       {4'h0, b_if.load_val}, mv[0], md[0], nv, nd);
            mv[0] <= nv; md[0] <= nd;
            model_next(2, 0, 31, 0, w_if.enable, w_if.clear, w_if.load, w_if.dir_in,
                       {4'h0, w_if.load_val}, mv[1], md[1], nv, nd);
            mv[1] <= nv; md[1] <= nd;
            model_next(3, 0, 999, 0, t_if.enable, t_if.clear, t_if.load, t_if.dir_in,
                       t_if.load_val, mv[2], md[2], nv, nd);
            mv[2] <= nv; md[2] <= nd;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check_dut("bounce", 0, 31, 1, {4'h0, b_if.q}, b_if.dir_out, b_if.tc,
                      b_if.enable, b_if.dir_in, mv[0], md[0]);
            check_dut("wrap", 0, 31, 0, {4'h0, w_if.q}, w_if.dir_out, w_if.tc,
                      w_if.enable, w_if.dir_in, mv[1], md[1]);
            check_dut("wrap3", 0, 999, 0, t_if.q, t_if.dir_out, t_if.tc,
                      t_if.enable, t_if.dir_in, mv[2], md[2]);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        b_if.enable = 0; b_if.clear = 0; b_if.dir_in = 1; b_if.load = 0; b_if.load_val = '0;
        w_if.enable = 0; w_if.clear = 0; w_if.dir_in = 1; w_if.load = 0; w_if.load_val = '0;
        t_if.enable = 0; t_if.clear = 0; t_if.dir_in = 1; t_if.load = 0; t_if.load_val = '0;
        rst_n = 1'b0;
        repeat (2) tick();
        cmp_en = 1'b1;
        chk("reset_q", 32'(b_if.q), 32'h00);
        chk("reset_dir", 32'(b_if.dir_out), 32'h1);
        rst_n = 1'b1;
        tick();

        $display("scenario bounce sweep");
        b_if.enable = 1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (n == 31) begin
                chk("bounce_top_q", 32'(b_if.q), 32'h31);
                chk("bounce_top_dir", 32'(b_if.dir_out), 32'h1);
                #1 chk("bounce_top_tc", 32'(b_if.tc), 32'h1);
            end
            if (n == 32) begin
                chk("bounce_rev_q", 32'(b_if.q), 32'h30);
                chk("bounce_rev_dir", 32'(b_if.dir_out), 32'h0);
            end
            if (n == 62) begin
                chk("bounce_bot_q", 32'(b_if.q), 32'h00);
                #1 chk("bounce_bot_tc", 32'(b_if.tc), 32'h1);
            end
            if (n == 63) begin
                chk("bounce_up_q", 32'(b_if.q), 32'h01);
                chk("bounce_up_dir", 32'(b_if.dir_out), 32'h1);
            end
        end
        chk("pre_clear_q", 32'(b_if.q), 32'h24);
        chk("pre_clear_dir", 32'(b_if.dir_out), 32'h0);

        $display("scenario clear beats enable");
        b_if.clear = 1;
        tick();
        b_if.clear = 0;
        chk("clear_q", 32'(b_if.q), 32'h00);
        chk("clear_dir", 32'(b_if.dir_out), 32'h1);

        $display("scenario async reset mid-count");
        repeat (17) tick();
        chk("pre_reset_q", 32'(b_if.q), 32'h17);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_q", 32'(b_if.q), 32'h00);
        chk("async_reset_dir", 32'(b_if.dir_out), 32'h1);
        #100;
        rst_n = 1'b1;
        chk("release_q", 32'(b_if.q), 32'h00);
        tick();
        chk("resume_q", 32'(b_if.q), 32'h01);

        $display("scenario parallel load (enabled=%0d)", LOAD_EN);
        b_if.load = 1; b_if.load_val = 8'h25;
        tick();
        chk("load_good_q", 32'(b_if.q), LOAD_EN ? 32'h25 : 32'h02);
        b_if.load_val = 8'h3A;
        tick();
        chk("load_baddigit_q", 32'(b_if.q), LOAD_EN ? 32'h26 : 32'h03);
        b_if.load_val = 8'h40;
        tick();
        chk("load_range_q", 32'(b_if.q), LOAD_EN ? 32'h27 : 32'h04);
        b_if.load = 0;
        b_if.enable = 0;

        $display("scenario wrap mode");
        w_if.clear = 1;
        tick();
        w_if.clear = 0; w_if.dir_in = 1; w_if.enable = 1;
        repeat (31) tick();
        chk("wrap_top_q", 32'(w_if.q), 32'h31);
        #1 chk("wrap_top_tc", 32'(w_if.tc), 32'h1);
        tick();
        chk("wrap_up_q", 32'(w_if.q), 32'h00);
        w_if.dir_in = 0;
        #1 chk("wrap_bot_tc", 32'(w_if.tc), 32'h1);
        chk("wrap_dir_pass", 32'(w_if.dir_out), 32'h0);
        tick();
        chk("wrap_down_q", 32'(w_if.q), 32'h31);
        for (int k = 0; k < 8; k++) begin
            w_if.enable = (k % 2 == 0);
            tick();
        end
        chk("wrap_half_rate_q", 32'(w_if.q), 32'h27);
        w_if.enable = 0;

        $display("scenario three digits");
        t_if.clear = 1;
        tick();
        t_if.clear = 0; t_if.dir_in = 1; t_if.enable = 1;
        repeat (99) tick();
        chk("t3_099", 32'(t_if.q), 32'h099);
        tick();
        chk("t3_100", 32'(t_if.q), 32'h100);
        repeat (99) tick();
        chk("t3_199", 32'(t_if.q), 32'h199);
        tick();
        chk("t3_200", 32'(t_if.q), 32'h200);
        repeat (799) tick();
        chk("t3_999", 32'(t_if.q), 32'h999);
        #1 chk("t3_top_tc", 32'(t_if.tc), 32'h1);
        tick();
        chk("t3_wrap_000", 32'(t_if.q), 32'h000);
        t_if.dir_in = 0;
        tick();
        chk("t3_wrap_999", 32'(t_if.q), 32'h999);
        repeat (899) tick();
        chk("t3_down_100", 32'(t_if.q), 32'h100);
        tick();
        chk("t3_down_099", 32'(t_if.q), 32'h099);
        t_if.enable = 0;

        $display("scenario random traffic");
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c == 1500) begin
                #1 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
            b_if.enable   = ($urandom_range(0, 3) != 0);
            b_if.clear    = ($urandom_range(0, 39) == 0);
            b_if.load     = ($urandom_range(0, 7) == 0);
            b_if.load_val = $urandom_range(0, 1) ? 8'(to_bcd($urandom_range(0, 40))) : 8'($urandom);
            b_if.dir_in   = 1'($urandom);
            w_if.enable   = ($urandom_range(0, 3) != 0);
            w_if.clear    = ($urandom_range(0, 39) == 0);
            w_if.load     = ($urandom_range(0, 7) == 0);
            w_if.load_val = $urandom_range(0, 1) ? 8'(to_bcd($urandom_range(0, 40))) : 8'($urandom);
            if ($urandom_range(0, 15) == 0) w_if.dir_in = ~w_if.dir_in;
            t_if.enable   = ($urandom_range(0, 3) != 0);
            t_if.clear    = ($urandom_range(0, 99) == 0);
            t_if.load     = ($urandom_range(0, 7) == 0);
            t_if.load_val = $urandom_range(0, 1) ? to_bcd($urandom_range(0, 999)) : 12'($urandom);
            if ($urandom_range(0, 15) == 0) t_if.dir_in = ~t_if.dir_in;
        end
        b_if.enable = 0; w_if.enable = 0; t_if.enable = 0;
        b_if.load = 0; w_if.load = 0; t_if.load = 0;
        b_if.clear = 0; w_if.clear = 0; t_if.clear = 0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
